// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard unit: operand-forward selects and the
// memory-wait FSM states. The execution-stage operand mux imports the same package.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } hz_state_e;

    // The younger producer (M) always wins over the older one (W).
    function automatic fwd_sel_e fwd_pick(input logic hit_m, input logic hit_w);
        fwd_sel_e sel;
        if (hit_m) begin
            sel = FWD_MEM;
        end else if (hit_w) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hz_shadow_stage.sv
// One pipeline-stage shadow of the register indices and controls the hazard
// unit tracks; instantiated for E, M and W.
module hz_shadow_stage
    import hazard_ctrl_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            bubble_i,
    input  logic [REGW-1:0] rs1_i,
    input  logic [REGW-1:0] rs2_i,
    input  logic [REGW-1:0] rd_i,
    input  logic            regwrite_i,
    input  logic            load_i,
    input  logic            memwrite_i,
    output logic [REGW-1:0] rs1_o,
    output logic [REGW-1:0] rs2_o,
    output logic [REGW-1:0] rd_o,
    output logic            regwrite_o,
    output logic            load_o,
    output logic            memwrite_o
);

    localparam int SW = 3 * REGW + 3;

    logic [SW-1:0] stage_d;
    logic [SW-1:0] stage_q;

    // Next-state select: hold beats bubble beats normal advance.
    always_comb begin
        stage_d = stage_q;
        if (hold_i) begin
            stage_d = stage_q;
        end else if (bubble_i) begin
            stage_d = '0;
        end else begin
            stage_d = {rs1_i, rs2_i, rd_i, regwrite_i, load_i, memwrite_i};
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign {rs1_o, rs2_o, rd_o, regwrite_o, load_o, memwrite_o} = stage_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// data-memory wait handling, driven from its own E/M/W shadow of the pipeline.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REGW = 5,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            RegWriteD,
    input  logic            ResultSrcD,
    input  logic            MemwriteD,
    input  logic            PCsrcE,
    input  logic            MemReadyM,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE,
    output logic [CNTW-1:0] StallCount
);

    logic [REGW-1:0] e_rs1_s, e_rs2_s, e_rd_s;
    logic [REGW-1:0] m_rs1_s, m_rs2_s, m_rd_s;
    logic [REGW-1:0] w_rs1_s, w_rs2_s, w_rd_s;
    logic            e_rw_s, e_ld_s, e_mw_s;
    logic            m_rw_s, m_ld_s, m_mw_s;
    logic            w_rw_s, w_ld_s, w_mw_s;

    hz_state_e       state_d, state_q;
    logic [CNTW-1:0] cnt_d, cnt_q;

    logic mem_stall_s, lu_hit_s, branch_s, lu_s;
    logic stall_fd_s, stall_e_s, flush_d_s, flush_e_s;
    logic hit_am_s, hit_aw_s, hit_bm_s, hit_bw_s;
    logic unused_ok_s;

    hz_shadow_stage #(.REGW(REGW)) u_shadow_e (
        .clk(clk), .rst(rst), .hold_i(stall_e_s), .bubble_i(flush_e_s),
        .rs1_i(Rs1D), .rs2_i(Rs2D), .rd_i(RdD),
        .regwrite_i(RegWriteD), .load_i(ResultSrcD), .memwrite_i(MemwriteD),
        .rs1_o(e_rs1_s), .rs2_o(e_rs2_s), .rd_o(e_rd_s),
        .regwrite_o(e_rw_s), .load_o(e_ld_s), .memwrite_o(e_mw_s)
    );

    hz_shadow_stage #(.REGW(REGW)) u_shadow_m (
        .clk(clk), .rst(rst), .hold_i(stall_e_s), .bubble_i(1'b0),
        .rs1_i(e_rs1_s), .rs2_i(e_rs2_s), .rd_i(e_rd_s),
        .regwrite_i(e_rw_s), .load_i(e_ld_s), .memwrite_i(e_mw_s),
        .rs1_o(m_rs1_s), .rs2_o(m_rs2_s), .rd_o(m_rd_s),
        .regwrite_o(m_rw_s), .load_o(m_ld_s), .memwrite_o(m_mw_s)
    );

    hz_shadow_stage #(.REGW(REGW)) u_shadow_w (
        .clk(clk), .rst(rst), .hold_i(stall_e_s), .bubble_i(1'b0),
        .rs1_i(m_rs1_s), .rs2_i(m_rs2_s), .rd_i(m_rd_s),
        .regwrite_i(m_rw_s), .load_i(m_ld_s), .memwrite_i(m_mw_s),
        .rs1_o(w_rs1_s), .rs2_o(w_rs2_s), .rd_o(w_rd_s),
        .regwrite_o(w_rw_s), .load_o(w_ld_s), .memwrite_o(w_mw_s)
    );

    // Memory-wait FSM next state, plus stall/flush arbitration.
    always_comb begin
        state_d     = state_q;
        mem_stall_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if ((m_ld_s || m_mw_s) && !MemReadyM) begin
                    mem_stall_s = 1'b1;
                    state_d     = ST_MEMWAIT;
                end else begin
                    state_d     = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                if (MemReadyM) begin
                    state_d     = ST_RUN;
                end else begin
                    mem_stall_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        lu_hit_s = e_ld_s && (e_rd_s != '0) && ((e_rd_s == Rs1D) || (e_rd_s == Rs2D));
        // A held E stage suppresses flushes; the branch re-presents once released.
        branch_s   = rst && PCsrcE && !mem_stall_s;
        lu_s       = rst && lu_hit_s && !mem_stall_s && !PCsrcE;
        stall_e_s  = rst && mem_stall_s;
        stall_fd_s = stall_e_s || lu_s;
        flush_d_s  = branch_s;
        flush_e_s  = branch_s || lu_s;
    end

    // Forward hit detection; x0 never forwards.
    always_comb begin
        hit_am_s = m_rw_s && (m_rd_s != '0) && (m_rd_s == e_rs1_s);
        hit_aw_s = w_rw_s && (w_rd_s != '0) && (w_rd_s == e_rs1_s);
        hit_bm_s = m_rw_s && (m_rd_s != '0) && (m_rd_s == e_rs2_s);
        hit_bw_s = w_rw_s && (w_rd_s != '0) && (w_rd_s == e_rs2_s);
        if (rst) begin
            ForwardAE = fwd_pick(hit_am_s, hit_aw_s);
            ForwardBE = fwd_pick(hit_bm_s, hit_bw_s);
        end else begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end
    end

    // Saturating stall-cycle counter next value.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_fd_s && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign StallF     = stall_fd_s;
    assign StallD     = stall_fd_s;
    assign StallE     = stall_e_s;
    assign FlushD     = flush_d_s;
    assign FlushE     = flush_e_s;
    assign StallCount = cnt_q;

    assign unused_ok_s = ^{e_rw_s, e_mw_s, m_rs1_s, m_rs2_s, w_rs1_s, w_rs2_s, w_ld_s, w_mw_s};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch priority,
// memory wait, counter saturation and reset during a memory wait.
module tb_hazard_ctrl;

    localparam int REGW = 5;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [REGW-1:0] Rs1D, Rs2D, RdD;
    logic            RegWriteD, ResultSrcD, MemwriteD, PCsrcE, MemReadyM;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            StallF, StallD, StallE, FlushD, FlushE;
    logic [CNTW-1:0] StallCount;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemwriteD(MemwriteD),
        .PCsrcE(PCsrcE), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then present the decode instruction and E/M inputs.
    task automatic cyc(input logic [REGW-1:0] rs1, input logic [REGW-1:0] rs2,
                       input logic [REGW-1:0] rd, input logic rw, input logic ld,
                       input logic mw, input logic pcs, input logic rdy);
        @(posedge clk);
        #1;
        Rs1D = rs1; Rs2D = rs2; RdD = rd;
        RegWriteD = rw; ResultSrcD = ld; MemwriteD = mw;
        PCsrcE = pcs; MemReadyM = rdy;
        #3;
    endtask

    initial begin
        rst = 1'b0;
        Rs1D = 5'd3; Rs2D = 5'd0; RdD = 5'd0;
        RegWriteD = 1'b0; ResultSrcD = 1'b0; MemwriteD = 1'b0;
        PCsrcE = 1'b1; MemReadyM = 1'b1;
        #12;
        chk("rst_flushd", 32'(FlushD), 32'd0);
        chk("rst_flushe", 32'(FlushE), 32'd0);
        chk("rst_stallf", 32'(StallF), 32'd0);
        chk("rst_cnt", 32'(StallCount), 32'd0);
        chk("rst_fwda", 32'(ForwardAE), 32'd0);
        PCsrcE = 1'b0;
        #6 rst = 1'b1;

        // Forwarding: back-to-back -> M, one apart -> W, both -> M wins.
        cyc(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fwd_none_a", 32'(ForwardAE), 32'd0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fwd_mem_a", 32'(ForwardAE), 32'd2);
        chk("fwd_mem_b", 32'(ForwardBE), 32'd0);
        chk("fwd_nostall", 32'(StallF), 32'd0);
        cyc(5'd9, 5'd10, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'd1, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'd2, 5'd8, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'd1, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fwd_wb_b", 32'(ForwardBE), 32'd1);
        chk("fwd_wb_a", 32'(ForwardAE), 32'd0);
        cyc(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'd4, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fwd_prio_a", 32'(ForwardAE), 32'd2);
        chk("fwd_prio_b", 32'(ForwardBE), 32'd2);
        cyc(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("x0_m_a", 32'(ForwardAE), 32'd0);
        chk("x0_m_b", 32'(ForwardBE), 32'd0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("x0_w_a", 32'(ForwardAE), 32'd0);

        // Memory wait: lw reaches M with three not-ready cycles.
        cyc(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mw_entry_stalle", 32'(StallE), 32'd1);
        chk("mw_entry_stallf", 32'(StallF), 32'd1);
        chk("mw_entry_stalld", 32'(StallD), 32'd1);
        chk("mw_noflushd", 32'(FlushD), 32'd0);
        chk("mw_noflushe", 32'(FlushE), 32'd0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mw_wait1", 32'(StallE), 32'd1);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mw_wait2", 32'(StallE), 32'd1);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mw_ready", 32'(StallE), 32'd0);
        chk("mw_cnt", 32'(StallCount), 32'd3);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mw_after", 32'(StallE), 32'd0);

        // Load-use: lw x7 ; add x1,x7,x2 (re-presented while stalled).
        cyc(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(5'd7, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lu_stallf", 32'(StallF), 32'd1);
        chk("lu_stalld", 32'(StallD), 32'd1);
        chk("lu_flushe", 32'(FlushE), 32'd1);
        chk("lu_stalle", 32'(StallE), 32'd0);
        chk("lu_flushd", 32'(FlushD), 32'd0);
        cyc(5'd7, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lu_once_stallf", 32'(StallF), 32'd0);
        chk("lu_once_flushe", 32'(FlushE), 32'd0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lu_fwd_a", 32'(ForwardAE), 32'd1);
        chk("lu_fwd_b", 32'(ForwardBE), 32'd0);
        chk("lu_cnt", 32'(StallCount), 32'd4);

        // Branch taken in the same cycle as a load-use hazard.
        cyc(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(5'd7, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("br_flushd", 32'(FlushD), 32'd1);
        chk("br_flushe", 32'(FlushE), 32'd1);
        chk("br_stallf", 32'(StallF), 32'd0);
        chk("br_stalld", 32'(StallD), 32'd0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("br_cnt", 32'(StallCount), 32'd4);

        // Long memory wait saturates the counter, then reset aborts the wait.
        cyc(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_stalle", 32'(StallE), 32'd1);
        chk("sat_cnt", 32'(StallCount), 32'd255);
        #2;
        rst = 1'b0;
        PCsrcE = 1'b1;
        #1;
        chk("rstw_stalle", 32'(StallE), 32'd0);
        chk("rstw_stallf", 32'(StallF), 32'd0);
        chk("rstw_flushd", 32'(FlushD), 32'd0);
        chk("rstw_cnt", 32'(StallCount), 32'd0);
        chk("rstw_fwda", 32'(ForwardAE), 32'd0);
        PCsrcE = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstw_release_stalle", 32'(StallE), 32'd0);
        chk("rstw_release_stallf", 32'(StallF), 32'd0);
        cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstw_release_cnt", 32'(StallCount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
